multi_alarm_disp_drvr: RTL



---
 rtl/alarm_pkg.sv | 26 ++
 rtl/snooze_timer.sv | 27 ++
 rtl/multi_alarm_disp_drvr.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared FSM encodings and channel-slice helper for the alarm display driver.
package alarm_pkg;

  localparam int STATE_W = 3;
  localparam int MAX_TW  = 32;
  localparam int MAX_CH  = 8;
  localparam int MAX_BUS = MAX_TW * MAX_CH;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    RINGING = 3'd1,
    SNOOZE  = 3'd2,
    LOCKOUT = 3'd3
  } state_t;

  function automatic logic [MAX_TW-1:0] chan_slice(
    input logic [MAX_BUS-1:0] bus,
    input int unsigned        idx,
    input int unsigned        w
  );
    logic [MAX_BUS-1:0] sh;
    sh = bus >> (idx * w);
    return sh[MAX_TW-1:0];
  endfunction

endpackage

// File: rtl/snooze_timer.sv
// Minute-tick down counter for snooze; expire flags the tick that reaches zero.
module snooze_timer #(
  parameter int SNOOZE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SNOOZE_W-1:0] load_val,
  input  logic                tick,
  input  logic                clear,
  output logic [SNOOZE_W-1:0] count,
  output logic                expire
);

  assign expire = tick && (count == SNOOZE_W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/multi_alarm_disp_drvr.sv
// Multi-channel alarm FSM with snooze and post-stop lockout, plus display mux.
module multi_alarm_disp_drvr
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS   = 2,
  parameter int TIME_W       = 16,
  parameter int SNOOZE_TICKS = 9,
  parameter int SNOOZE_W     = 8,
  parameter int MAX_SNOOZES  = 3,
  parameter int IDX_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         minute_tick,
  input  logic [TIME_W-1:0]            current_time,
  input  logic [NUM_ALARMS*TIME_W-1:0] alarm_time,
  input  logic [NUM_ALARMS-1:0]        alarm_en,
  input  logic                         show_alarm,
  input  logic [IDX_W-1:0]             show_sel,
  input  logic                         do_snooze,
  input  logic                         stop_alarm,
  output logic [TIME_W-1:0]            display,
  output logic                         sound_alarm,
  output logic [IDX_W-1:0]             active_alarm,
  output logic [SNOOZE_W-1:0]          snooze_count,
  output logic [2:0]                   state_out
);

  localparam int USED_W =
    (MAX_SNOOZES < 2) ? 1 : $clog2(MAX_SNOOZES + 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     active_d;
  logic [USED_W-1:0]    used_q, used_d;
  logic                 snz_q;
  logic                 snz_edge;
  logic [MAX_BUS-1:0]   bus_w;
  logic [NUM_ALARMS-1:0] match;
  logic                 any_match;
  logic [IDX_W-1:0]     first_idx;
  logic [TIME_W-1:0]    act_time;
  logic                 act_en;
  logic [IDX_W-1:0]     sel_idx;
  logic [TIME_W-1:0]    sel_time;
  logic                 t_load;
  logic                 t_clear;
  logic                 t_expire;
  logic [MAX_TW-1:0]    tmp_a;
  logic [MAX_TW-1:0]    tmp_s;

  assign snz_edge = do_snooze && !snz_q;

  always_comb begin
    bus_w = '0;
    bus_w[NUM_ALARMS*TIME_W-1:0] = alarm_time;
  end

  always_comb begin
    match     = '0;
    any_match = 1'b0;
    first_idx = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      tmp_s    = chan_slice(bus_w, i, TIME_W);
      match[i] = alarm_en[i] && (current_time == tmp_s[TIME_W-1:0]);
    end
    // Walk downward so the lowest matching channel is left in first_idx.
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (match[i]) begin
        first_idx = IDX_W'(i);
        any_match = 1'b1;
      end
    end
  end

  always_comb begin
    tmp_a    = chan_slice(bus_w, 32'(active_alarm), TIME_W);
    act_time = tmp_a[TIME_W-1:0];
    act_en   = alarm_en[active_alarm];
    sel_idx  = (32'(show_sel) < NUM_ALARMS) ? show_sel : '0;
  end

  logic [MAX_TW-1:0] tmp_d;
  always_comb begin
    tmp_d    = chan_slice(bus_w, 32'(sel_idx), TIME_W);
    sel_time = tmp_d[TIME_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_alarm;
    used_d   = used_q;
    t_load   = 1'b0;
    t_clear  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_match) begin
          state_d  = RINGING;
          active_d = first_idx;
          used_d   = '0;
        end
      end
      RINGING: begin
        if (!act_en) begin
          state_d = IDLE;
          t_clear = 1'b1;
        end else if (stop_alarm) begin
          state_d = LOCKOUT;
        end else if (snz_edge && (int'(used_q) < MAX_SNOOZES)) begin
          state_d = SNOOZE;
          t_load  = 1'b1;
          used_d  = used_q + 1'b1;
        end
      end
      SNOOZE: begin
        if (!act_en) begin
          state_d = IDLE;
          t_clear = 1'b1;
        end else if (stop_alarm) begin
          state_d = LOCKOUT;
          t_clear = 1'b1;
        end else if (t_expire) begin
          state_d = RINGING;
        end
      end
      LOCKOUT: begin
        if (!act_en || current_time != act_time) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        t_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      active_alarm <= '0;
      used_q       <= '0;
      snz_q        <= 1'b0;
      sound_alarm  <= 1'b0;
      display      <= '0;
    end else begin
      state_q      <= state_d;
      active_alarm <= active_d;
      used_q       <= used_d;
      snz_q        <= do_snooze;
      sound_alarm  <= (state_d == RINGING);
      display      <= show_alarm ? sel_time : current_time;
    end
  end

  assign state_out = state_q;

  snooze_timer #(
    .SNOOZE_W (SNOOZE_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (SNOOZE_W'(SNOOZE_TICKS)),
    .tick     (minute_tick),
    .clear    (t_clear),
    .count    (snooze_count),
    .expire   (t_expire)
  );

endmodule
